generate_dat_shift_var: RTL and testbench

Runtime-programmable delay line for aligning CONV MAC operand and partial-sum streams whose skew depends on the layer configuration. It generalises the fixed-depth data shifter with the following additions:
- a selectable tap depth, 1..MAX_DEPTH;
- a per-beat valid sideband;
- a global stall enable;
- a flush.

It sits between the dat/wt fetch paths and the MAC array, and is reprogrammed once per layer.

---
 rtl/generate_dat_shift_var.sv | 116 +++++++++++
 tb/tb_generate_dat_shift_var.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/generate_dat_shift_var.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generate_dat_shift_var: runtime-depth delay line with valid sideband,      |
// | stall and flush. Optional macro SHIFT_OUT_REG_EN adds an output register.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module generate_dat_shift_var #(
  parameter int DATA_WIDTH = 256,
  parameter int MAX_DEPTH  = 16,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [DEPTH_W-1:0]    cfg_depth,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic [DEPTH_W-1:0]    depth_r
);

  logic [DATA_WIDTH-1:0] r_dat [MAX_DEPTH];
  logic [MAX_DEPTH-1:0]  r_vld;
  logic [DEPTH_W-1:0]    r_depth;

  logic                  w_drop;
  logic [DEPTH_W-1:0]    w_depth_clamp;
  logic [MAX_DEPTH-1:0]  w_mask;
  logic                  w_tap_vld;
  logic [DATA_WIDTH-1:0] w_tap_dat;
  logic                  w_line_busy;

  assign w_drop = flush | cfg_load;

  assign w_depth_clamp = (cfg_depth == '0)                  ? DEPTH_W'(1) :
                         (cfg_depth > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) :
                                                             cfg_depth;

  // Data stages carry no reset; validity is tracked solely by r_vld.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (en) r_dat[gi] <= data_in;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (en) r_dat[gi] <= r_dat[gi-1];
        end
      end
      assign w_mask[gi] = (DEPTH_W'(gi) < r_depth);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_depth <= DEPTH_W'(MAX_DEPTH);
    end else begin
      if (w_drop) begin
        r_vld <= '0;
      end else if (en) begin
        r_vld <= {r_vld[MAX_DEPTH-2:0], in_vld};
      end
      if (cfg_load) r_depth <= w_depth_clamp;
    end
  end

  always_comb begin
    w_tap_vld = 1'b0;
    w_tap_dat = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (r_depth == DEPTH_W'(i + 1)) begin
        w_tap_vld = r_vld[i];
        w_tap_dat = r_vld[i] ? r_dat[i] : '0;
      end
    end
  end

  assign w_line_busy = |(r_vld & w_mask);
  assign depth_r     = r_depth;

`ifdef SHIFT_OUT_REG_EN
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      if (w_drop) begin
        r_out_vld <= 1'b0;
      end else if (en) begin
        r_out_vld <= w_tap_vld;
      end
      if (en) r_out_dat <= w_tap_dat;
    end
  end

  assign out_vld  = r_out_vld;
  assign data_out = r_out_vld ? r_out_dat : '0;
  assign busy     = w_line_busy | r_out_vld;
`else
  assign out_vld  = w_tap_vld;
  assign data_out = w_tap_dat;
  assign busy     = w_line_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_generate_dat_shift_var.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_generate_dat_shift_var: scoreboard bench with a queue-based model of the |
// | variable-depth delay line. Honours SHIFT_OUT_REG_EN when defined.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_generate_dat_shift_var;

  localparam int DW        = 256;
  localparam int MAX_DEPTH = 16;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [DEPTH_W-1:0] cfg_depth = '0;
  logic               en = 1'b0;
  logic               flush = 1'b0;
  logic               in_vld = 1'b0;
  logic [DW-1:0]      data_in = '0;
  logic               out_vld;
  logic [DW-1:0]      data_out;
  logic               busy;
  logic [DEPTH_W-1:0] depth_r;

  generate_dat_shift_var #(
    .DATA_WIDTH(DW),
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_load (cfg_load),
    .cfg_depth(cfg_depth),
    .en       (en),
    .flush    (flush),
    .in_vld   (in_vld),
    .data_in  (data_in),
    .out_vld  (out_vld),
    .data_out (data_out),
    .busy     (busy),
    .depth_r  (depth_r)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } beat_t;

  // Reference: hist[k] is the beat accepted k enabled edges ago.
  beat_t         hist[$];
  logic [DW-1:0] exp_q[$];
  int            m_depth;
  logic          m_out_v;
  logic          m_busy;
`ifdef SHIFT_OUT_REG_EN
  beat_t         m_oreg;
`endif

  int            checks = 0;
  int            failures = 0;
  logic          en_last = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void recompute();
    m_busy = 1'b0;
    for (int i = 0; i < m_depth; i++) m_busy |= hist[i].v;
`ifdef SHIFT_OUT_REG_EN
    m_out_v = m_oreg.v;
    m_busy |= m_oreg.v;
`else
    m_out_v = hist[m_depth-1].v;
`endif
  endfunction

  function automatic void model_reset();
    beat_t b;
    b = '0;
    hist.delete();
    repeat (MAX_DEPTH) hist.push_back(b);
    exp_q.delete();
    m_depth = MAX_DEPTH;
`ifdef SHIFT_OUT_REG_EN
    m_oreg = '0;
`endif
    recompute();
  endfunction

  function automatic void model_step(input logic e, input logic iv, input logic fl,
                                     input logic cl, input int cd, input logic [DW-1:0] d);
    logic  drop;
    beat_t b;
    drop = fl | cl;
`ifdef SHIFT_OUT_REG_EN
    if (e) m_oreg = hist[m_depth-1];
    if (drop) m_oreg.v = 1'b0;
`endif
    if (e) begin
      b.v = iv & ~drop;
      b.d = d;
      hist.push_front(b);
      void'(hist.pop_back());
    end
    if (drop) foreach (hist[i]) hist[i].v = 1'b0;
    if (cl) m_depth = (cd == 0) ? 1 : ((cd > MAX_DEPTH) ? MAX_DEPTH : cd);
    if (drop) exp_q.delete();
    else if (e && iv) exp_q.push_back(d);
    recompute();
  endfunction

  // Called between edges; returns at negedge+1 after one modelled posedge.
  task automatic step(input logic e, input logic iv, input logic fl, input logic cl,
                      input int cd, input logic [DW-1:0] d);
    en = e; in_vld = iv; flush = fl; cfg_load = cl;
    cfg_depth = DEPTH_W'(cd); data_in = d;
    @(posedge clk);
    model_step(e, iv, fl, cl, cd, d);
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic stall(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic cfg(input int dep);
    step(1'b1, 1'b0, 1'b0, 1'b1, dep, '0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) en_last <= en;

  // Monitor: a freshly presented beat is popped; a held one must not change.
  always @(negedge clk) begin
    chk("out_vld", {255'b0, out_vld}, {255'b0, m_out_v});
    chk("busy", {255'b0, busy}, {255'b0, m_busy});
    chk("depth_r", DW'(depth_r), DW'(m_depth));
    if (out_vld) begin
      if (en_last) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=%0h required=none t=%0t", data_out, $time);
        end else begin
          held = exp_q.pop_front();
          chk("data_out", data_out, held);
        end
      end else begin
        chk("data_hold", data_out, held);
      end
    end else begin
      chk("data_zero", data_out, '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    cfg(4);
    for (int i = 0; i < 8; i++) beat(DW'(8'hA1 + i));
    idle(6);

    cfg(0);
    beat(DW'(8'h55));
    idle(3);
    cfg(31);
    beat(DW'(8'h77));
    idle(18);

    cfg(3);
    beat(DW'(8'h11));
    idle(1);
    stall(5);
    idle(1);
    stall(3);
    idle(4);

    cfg(6);
    for (int i = 0; i < 4; i++) beat(DW'(8'hC0 + i));
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, DW'(8'h99));
    idle(8);

    cfg(8);
    for (int i = 0; i < 5; i++) beat(DW'(8'hD0 + i));
    step(1'b1, 1'b1, 1'b0, 1'b1, 2, DW'(8'hEE));
    for (int i = 0; i < 4; i++) beat(DW'(8'hE0 + i));
    idle(4);

    step(1'b0, 1'b0, 1'b1, 1'b0, 0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5, '0);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 40) == 0,
           ($urandom % 50) == 0, int'($urandom % 32), rnd_data());
    end
    idle(20);
    chk("sb_drain", DW'(exp_q.size()), '0);

    cfg(16);
    for (int i = 0; i < 16; i++) beat(rnd_data());
    rst = 1'b1;
    #1;
    chk("rst_out_vld", {255'b0, out_vld}, '0);
    chk("rst_busy", {255'b0, busy}, '0);
    chk("rst_data_out", data_out, '0);
    chk("rst_depth_r", DW'(depth_r), DW'(MAX_DEPTH));
    en = 1'b0; in_vld = 1'b0; flush = 1'b0; cfg_load = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    chk("sb_final", DW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
